turn_signal_input_conditioner: RTL and testbench

Input stage that sits directly upstream of the Thunderbird turn-signal FSM. It takes raw, asynchronous, bouncing board switches for left, right and hazard. For each one it synchronises, debounces and priority-arbitrates the input. It then presents clean, mutually consistent, registered LEFT/RIGHT/HAZ levels to the FSM, plus a one-cycle change-event pulse and a conflict flag.

---
 rtl/turn_signal_pkg.sv | 42 ++++
 rtl/debounce_sync.sv | 74 +++++++
 rtl/turn_signal_input_conditioner.sv | 88 ++++++++
 tb/tb_turn_signal_input_conditioner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/turn_signal_pkg.sv
// Shared constants, request bundle layout and arbitration rule for the
// turn-signal input conditioner.
package turn_signal_pkg;

  // Board defaults (50 MHz clock, 20 ms debounce window)
  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int unsigned CNT_W_DEF           = 20;

  // Short debounce window used for simulation
  localparam int unsigned DEBOUNCE_CYCLES_SIM = 4;

  // Bit positions inside the {haz,left,right} request bundle
  localparam int unsigned REQ_W     = 3;
  localparam int unsigned REQ_RIGHT = 0;
  localparam int unsigned REQ_LEFT  = 1;
  localparam int unsigned REQ_HAZ   = 2;

  // Clean request levels presented to the turn-signal FSM
  typedef struct packed {
    logic haz;
    logic left;
    logic right;
  } req_t;

  // Arbitrated result: mutually exclusive requests plus the conflict flag
  typedef struct packed {
    req_t req;
    logic conflict;
  } arb_t;

  // Hazard dominates; left and right together cancel to a conflict
  function automatic arb_t arbitrate(input logic [REQ_W-1:0] d);
    arb_t a;
    a.req.haz   = d[REQ_HAZ];
    a.req.left  = d[REQ_LEFT]  & ~d[REQ_RIGHT] & ~d[REQ_HAZ];
    a.req.right = d[REQ_RIGHT] & ~d[REQ_LEFT]  & ~d[REQ_HAZ];
    a.conflict  = d[REQ_LEFT]  &  d[REQ_RIGHT] & ~d[REQ_HAZ];
    return a;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Single-bit synchroniser chain followed by a stability-window debouncer.
module debounce_sync
  import turn_signal_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);

  // Terminal count: the input has differed for the whole window
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject illegal parameter combinations at elaboration
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_sync: SYNC_STAGES must be 2..4");
  end
  if (CNT_W < 1 || CNT_W > 62) begin : g_bad_cnt_w
    $error("debounce_sync: CNT_W out of range");
  end
  if (DEBOUNCE_CYCLES < 1 ||
      (64'(DEBOUNCE_CYCLES) - 64'd1) >= (64'd1 << CNT_W)) begin : g_bad_deb
    $error("debounce_sync: DEBOUNCE_CYCLES-1 must fit in CNT_W bits");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_stable;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_s;
  logic                   w_stable_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Shift the raw level through the synchroniser chain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_i};
    end
  end

  // Count consecutive cycles the synchronised level differs from the stable one
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = r_cnt + CNT_W'(1);
    if (w_s == r_stable) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CNT_LAST) begin
      w_stable_nxt = w_s;
      w_cnt_nxt    = '0;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_stable <= w_stable_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign stable_o = r_stable;

endmodule

// File: rtl/turn_signal_input_conditioner.sv
// Conditions raw left/right/hazard switches into clean, mutually exclusive,
// registered request levels for the turn-signal FSM.
module turn_signal_input_conditioner
  import turn_signal_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic left_raw,
  input  logic right_raw,
  input  logic haz_raw,
  output logic left_o,
  output logic right_o,
  output logic haz_o,
  output logic conflict_o,
  output logic evt_o
);

  logic [REQ_W-1:0] w_d;
  arb_t             w_arb;
  logic             w_evt_nxt;

  req_t             r_req;
  logic             r_conflict;
  logic             r_evt;

  debounce_sync #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_left (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (left_raw),
    .stable_o (w_d[REQ_LEFT])
  );

  debounce_sync #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_right (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (right_raw),
    .stable_o (w_d[REQ_RIGHT])
  );

  debounce_sync #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_haz (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (haz_raw),
    .stable_o (w_d[REQ_HAZ])
  );

  // Arbitrate debounced levels and flag any change of the request bundle
  always_comb begin
    w_arb     = arbitrate(w_d);
    w_evt_nxt = (w_arb.req != r_req);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req      <= '0;
      r_conflict <= 1'b0;
      r_evt      <= 1'b0;
    end else begin
      r_req      <= w_arb.req;
      r_conflict <= w_arb.conflict;
      r_evt      <= w_evt_nxt;
    end
  end

  assign left_o     = r_req.left;
  assign right_o    = r_req.right;
  assign haz_o      = r_req.haz;
  assign conflict_o = r_conflict;
  assign evt_o      = r_evt;

endmodule

// File: tb/tb_turn_signal_input_conditioner.sv
// Randomised bench for turn_signal_input_conditioner with a window-based
// reference model feeding a per-cycle scoreboard.
module tb_turn_signal_input_conditioner;
  import turn_signal_pkg::*;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = DEBOUNCE_CYCLES_SIM;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left_raw = 1'b0, right_raw = 1'b0, haz_raw = 1'b0;
  logic left_o, right_o, haz_o, conflict_o, evt_o;

  int errors = 0;
  int checks = 0;

  turn_signal_input_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (CNT_W_DEF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .left_raw   (left_raw),
    .right_raw  (right_raw),
    .haz_raw    (haz_raw),
    .left_o     (left_o),
    .right_o    (right_o),
    .haz_o      (haz_o),
    .conflict_o (conflict_o),
    .evt_o      (evt_o)
  );

  always #5 clk = ~clk;

  // Expected outputs after one rising edge: {haz,left,right,conflict,evt}
  logic [4:0] exp_q[$];

  // Reference model state
  logic [2:0] raw_hist[$];   // raw samples, seeded with SYNC zeros at reset
  logic [2:0] s_hist[$];     // synchronised samples since reset, last DEB kept
  logic [2:0] m_d = '0;      // accepted levels
  logic [2:0] m_out = '0;    // {haz,left,right} outputs
  logic [2:0] raw_now, s_now, d_new, out_new;
  logic       conf_new, all_diff;

  // Model: a level is accepted once the synchronised input has shown the
  // opposite value at each of the last DEB edges; outputs follow one edge later.
  always @(posedge clk) begin
    raw_now            = '0;
    raw_now[REQ_HAZ]   = haz_raw;
    raw_now[REQ_LEFT]  = left_raw;
    raw_now[REQ_RIGHT] = right_raw;
    if (reset) begin
      raw_hist.delete();
      for (int i = 0; i < int'(SYNC); i++) raw_hist.push_back(3'b000);
      s_hist.delete();
      m_d   = '0;
      m_out = '0;
      exp_q.push_back(5'b00000);
    end else begin
      out_new    = 3'b000;
      out_new[2] = m_d[REQ_HAZ];
      out_new[1] = m_d[REQ_LEFT] && !m_d[REQ_RIGHT] && !m_d[REQ_HAZ];
      out_new[0] = m_d[REQ_RIGHT] && !m_d[REQ_LEFT] && !m_d[REQ_HAZ];
      conf_new   = m_d[REQ_LEFT] && m_d[REQ_RIGHT] && !m_d[REQ_HAZ];
      exp_q.push_back({out_new, conf_new, (out_new != m_out)});
      m_out = out_new;

      s_now = raw_hist[raw_hist.size() - SYNC];
      raw_hist.push_back(raw_now);
      if (raw_hist.size() > 8) void'(raw_hist.pop_front());
      s_hist.push_back(s_now);
      if (s_hist.size() > DEB) void'(s_hist.pop_front());

      d_new = m_d;
      for (int b = 0; b < 3; b++) begin
        all_diff = (s_hist.size() == DEB);
        foreach (s_hist[j]) if (s_hist[j][b] == m_d[b]) all_diff = 1'b0;
        if (all_diff) d_new[b] = ~m_d[b];
      end
      m_d = d_new;
    end
  end

  // Monitor: compare DUT outputs against the model on the falling edge
  logic [4:0] exp_v, got_v;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {haz_o, left_o, right_o, conflict_o, evt_o};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t {haz,left,right,conflict,evt} got=%b want=%b",
                 $time, got_v, exp_v);
      end
      checks++;
      if ($countones({haz_o, left_o, right_o}) > 1) begin
        errors++;
        $display("FAIL exclusive t=%0t {haz,left,right} got=%b want at most one set",
                 $time, {haz_o, left_o, right_o});
      end
    end
  end

  task automatic drive(input logic l, input logic r, input logic h, input int n);
    left_raw  = l;
    right_raw = r;
    haz_raw   = h;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  int lat;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3);

    // Step left and measure edges until left_o rises
    left_raw = 1'b1;
    lat = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
      if (left_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != int'(SYNC + DEB + 1)) begin
      errors++;
      $display("FAIL step_latency got=%0d edges want=%0d", lat, SYNC + DEB + 1);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 4);

    // Chatter shorter than the window, then a real hold
    pulse_reset(1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 3);
      drive(1'b0, 1'b0, 1'b0, 3);
    end
    drive(1'b1, 1'b0, 1'b0, 12);

    // Left+right conflict, then right alone
    drive(1'b1, 1'b1, 1'b0, 12);
    drive(1'b0, 1'b1, 1'b0, 12);

    // Hazard overrides right, then releases it
    drive(1'b0, 1'b1, 1'b1, 12);
    drive(1'b0, 1'b1, 1'b0, 12);

    // Reset in the middle of a debounce count
    pulse_reset(1);
    drive(1'b0, 1'b0, 1'b0, 12);
    drive(1'b1, 1'b0, 1'b0, 3);
    pulse_reset(1);
    drive(1'b1, 1'b0, 1'b0, 12);

    // All inputs high through reset release
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 3);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 12);

    // Random segments: mix of glitches and accepted changes, rare resets
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset(int'($urandom_range(1, 3)));
      drive(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
            int'($urandom_range(1, 9)));
    end

    drive(1'b0, 1'b0, 1'b0, 12);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
